// File: rtl/audio_pkg.sv
// Note dividers (clock cycles per tone period at 100 MHz), the default melody
// table and the sequencer state encoding shared by the melody player.
package audio_pkg;

    localparam logic [20:0] NOTE_E2   = 21'd1204819;
    localparam logic [20:0] NOTE_F2   = 21'd1149425;
    localparam logic [20:0] NOTE_FA   = 21'd1086957;
    localparam logic [20:0] NOTE_Fa   = 21'd1075269;
    localparam logic [20:0] NOTE_LA   = 21'd909091;
    localparam logic [20:0] NOTE_La   = 21'd854701;
    localparam logic [20:0] NOTE_REST = 21'd0;

    // Entry 0 sits in the least significant slot and plays first.
    localparam logic [8*21-1:0] MEL_DEFAULT = {
        NOTE_REST, NOTE_La, NOTE_LA, NOTE_Fa,
        NOTE_FA,   NOTE_F2, NOTE_E2, NOTE_E2
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: low for the first div/2 counts of each period, high
// for the rest; div == 0 is silent.
module tone_gen #(
    parameter int DIV_W = 21
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             wave_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    // clr/en/div describe the coming cycle, so the registered wave lines up
    // with the counter value it was derived from.
    always_comb begin
        cnt_d = '0;
        if (en_i && !clr_i && (div_i != '0) && (cnt_q < div_i - 1'b1))
            cnt_d = cnt_q + 1'b1;
        wave_d = en_i && (div_i != '0) && (cnt_d >= (div_i >> 1));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: steps through a table of note dividers with fixed note and
// gap durations, one-shot or looping, and drives a single tone generator.
module melody_player
    import audio_pkg::*;
#(
    parameter int                         NUM_NOTES  = 8,
    parameter int                         IDX_W      = 3,
    parameter int                         DIV_W      = 21,
    parameter logic [NUM_NOTES*DIV_W-1:0] MELODY     = MEL_DEFAULT,
    parameter int                         NOTE_TICKS = 50_000_000,
    parameter int                         GAP_TICKS  = 5_000_000,
    parameter int                         DUR_W      = 28
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             loop_i,
    output logic             audio_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] note_idx_o
);

    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NOTES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               loop_q, loop_d;
    logic               busy_q, done_q, done_d;
    logic               adv, tone_clr, tone_en;
    logic [DIV_W-1:0]   tone_div;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dur_d    = dur_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        adv      = 1'b0;
        tone_clr = 1'b0;
        tone_en  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d  = ST_PLAY;
                idx_d    = '0;
                dur_d    = '0;
                loop_d   = loop_i;
                tone_clr = 1'b1;
            end
            ST_PLAY: if (dur_q == NOTE_LAST) begin
                dur_d = '0;
                if (GAP_TICKS > 0) state_d = ST_GAP;
                else               adv     = 1'b1;
            end else begin
                dur_d = dur_q + 1'b1;
            end
            ST_GAP: if (dur_q == GAP_LAST) begin
                dur_d = '0;
                adv   = 1'b1;
            end else begin
                dur_d = dur_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            if (idx_q != IDX_LAST) begin
                idx_d    = idx_q + 1'b1;
                state_d  = ST_PLAY;
                tone_clr = 1'b1;
            end else if (loop_q) begin
                idx_d    = '0;
                state_d  = ST_PLAY;
                tone_clr = 1'b1;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
        // stop beats start and completion alike
        if (stop_i) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            dur_d    = '0;
            done_d   = 1'b0;
            tone_clr = 1'b0;
        end
        tone_en = (state_d == ST_PLAY);
    end

    assign tone_div = MELODY[int'(idx_d)*DIV_W +: DIV_W];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dur_q   <= '0;
            loop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            loop_q  <= loop_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
        end
    end

    tone_gen #(.DIV_W(DIV_W)) u_tone (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (tone_clr),
        .en_i    (tone_en),
        .div_i   (tone_div),
        .wave_o  (audio_o)
    );

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign note_idx_o = idx_q;

endmodule
